qvec_reply: RTL and testbench

- Downstream partner of the QBUS interrupt controller (qint).
- When qint raises assert_vector during an interrupt-acknowledge cycle, this block does the device side of the vector transfer:
  - drives the interrupt vector onto TDAL;
  - asserts TRPLY;
  - waits for the bus master to drop RDIN;
  - releases the bus.
- Reports completion or abort to the device logic so the pending request is cleared exactly once.

---
 rtl/qvec_reply_pkg.sv | 32 +++
 rtl/qvec_reply_qsync2.sv | 34 +++
 rtl/qvec_reply.sv | 191 +++++++++++++++++++
 tb/tb_qvec_reply.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/qvec_reply_pkg.sv
// -----------------------------------------------------------------------------
// qvec_reply_pkg
// Shared definitions for the QBUS interrupt-vector reply slice:
//   - qvec_state_t : 3-bit encoding of the reply sequencer states
//   - DAL_W        : width of the DAL data path driven onto the bus (22)
//   - VEC_W        : width of the CSR-programmed interrupt vector (16)
//   - dalVector()  : forms the DAL word for a vector (low two bits cleared,
//                    upper DAL bits zero)
// -----------------------------------------------------------------------------
package qvec_reply_pkg;

  localparam int DAL_W = 22;
  localparam int VEC_W = 16;

  typedef enum logic [2:0] {
    QVEC_IDLE  = 3'd0,
    QVEC_SETUP = 3'd1,
    QVEC_REPLY = 3'd2,
    QVEC_HOLD  = 3'd3,
    QVEC_ABORT = 3'd4,
    QVEC_CLEAR = 3'd5
  } qvec_state_t;

  // Vectors are always longword aligned on the bus, so the two low bits are
  // forced to zero regardless of what the CSR holds.
  function automatic logic [DAL_W-1:0] dalVector(input logic [VEC_W-1:0] vec);
    logic [VEC_W-1:0] masked;
    masked = vec & ~VEC_W'(3);
    return DAL_W'(masked);
  endfunction

endpackage

// File: rtl/qvec_reply_qsync2.sv
// -----------------------------------------------------------------------------
// qsync2
// Two-flop synchronizer for asynchronous QBUS control inputs. Output lags the
// input by two clock edges. Reset clears both flops to 0.
// Ports:
//   qclk     in  1  system clock
//   reset    in  1  asynchronous active-high reset
//   i_async  in  1  asynchronous input
//   o_sync   out 1  synchronized copy of i_async
// -----------------------------------------------------------------------------
module qsync2 (
  input  logic qclk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/qvec_reply.sv
// -----------------------------------------------------------------------------
// qvec_reply
// Device side of the QBUS interrupt-vector transfer. When qint grants the IAK
// cycle (assert_vector) and the master asserts DIN, the vector is driven onto
// TDAL, TRPLY is raised after a setup delay, and the bus is released once the
// master drops DIN. Completion or abandonment is reported with a single pulse.
// Optional build macro: QVEC_TIMEOUT_EN adds a forced release if DIN is held
// for TIMEOUT_CYC cycles in REPLY.
// Ports:
//   qclk           in  1   system clock (20 MHz)
//   reset          in  1   asynchronous active-high reset
//   assert_vector  in  1   IAK grant level from qint
//   RDIN           in  1   QBUS DIN sense (asynchronous)
//   vector         in  16  CSR vector, latched at start, bits 1:0 ignored
//   TDAL           out 22  data to DAL drivers
//   dal_oe         out 1   DAL transmitter enable
//   TRPLY          out 1   QBUS RPLY
//   vector_done    out 1   one-cycle pulse, transfer completed
//   vector_abort   out 1   one-cycle pulse, transfer abandoned
//   busy           out 1   high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module qvec_reply
  import qvec_reply_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic             qclk,
  input  logic             reset,
  input  logic             assert_vector,
  input  logic             RDIN,
  input  logic [VEC_W-1:0] vector,
  output logic [DAL_W-1:0] TDAL,
  output logic             dal_oe,
  output logic             TRPLY,
  output logic             vector_done,
  output logic             vector_abort,
  output logic             busy
);

  // One counter width covers every interval this block times.
  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_SH > TIMEOUT_CYC) ? MAX_SH : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             w_rdinS;
  qvec_state_t      r_state,  w_nextState;
  logic [CNT_W-1:0] r_cnt,    w_nextCnt;
  logic [DAL_W-1:0] r_tdal,   w_nextTdal;
  logic             r_dalOe,  w_nextDalOe;
  logic             r_trply,  w_nextTrply;
  logic             r_done,   w_nextDone;
  logic             r_abort,  w_nextAbort;
  logic             r_busy,   w_nextBusy;
`ifdef QVEC_TIMEOUT_EN
  logic [CNT_W-1:0] r_toCnt,  w_nextToCnt;
`endif

  qsync2 u_rdinSync (
    .qclk    (qclk),
    .reset   (reset),
    .i_async (RDIN),
    .o_sync  (w_rdinS)
  );

  // State, counters and every output are registered together so the bus
  // sees glitch-free levels; reset drops the bus immediately.
  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      r_state <= QVEC_IDLE;
      r_cnt   <= '0;
      r_tdal  <= '0;
      r_dalOe <= 1'b0;
      r_trply <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
`ifdef QVEC_TIMEOUT_EN
      r_toCnt <= '0;
`endif
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_tdal  <= w_nextTdal;
      r_dalOe <= w_nextDalOe;
      r_trply <= w_nextTrply;
      r_done  <= w_nextDone;
      r_abort <= w_nextAbort;
      r_busy  <= w_nextBusy;
`ifdef QVEC_TIMEOUT_EN
      r_toCnt <= w_nextToCnt;
`endif
    end
  end

  // Next-state and next-output logic. Outputs hold by default; pulses default
  // low. In SETUP the DIN-drop check comes before the counter test so a master
  // giving up on the expiry edge still aborts.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextTdal  = r_tdal;
    w_nextDalOe = r_dalOe;
    w_nextTrply = r_trply;
    w_nextDone  = 1'b0;
    w_nextAbort = 1'b0;
`ifdef QVEC_TIMEOUT_EN
    w_nextToCnt = r_toCnt;
`endif
    case (r_state)
      QVEC_IDLE: begin
        if (assert_vector && w_rdinS) begin
          w_nextState = QVEC_SETUP;
          w_nextTdal  = dalVector(vector);
          w_nextDalOe = 1'b1;
          w_nextCnt   = CNT_W'(SETUP_CYC - 1);
        end
      end
      QVEC_SETUP: begin
        if (!w_rdinS) begin
          w_nextState = QVEC_ABORT;
          w_nextTdal  = '0;
          w_nextDalOe = 1'b0;
          w_nextTrply = 1'b0;
          w_nextAbort = 1'b1;
        end else if (r_cnt == '0) begin
          w_nextState = QVEC_REPLY;
          w_nextTrply = 1'b1;
`ifdef QVEC_TIMEOUT_EN
          w_nextToCnt = CNT_W'(TIMEOUT_CYC - 1);
`endif
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      QVEC_REPLY: begin
        if (!w_rdinS) begin
          w_nextState = QVEC_HOLD;
          w_nextTrply = 1'b0;
          w_nextCnt   = CNT_W'(HOLD_CYC - 1);
        end
`ifdef QVEC_TIMEOUT_EN
        else if (r_toCnt == '0) begin
          w_nextState = QVEC_ABORT;
          w_nextTdal  = '0;
          w_nextDalOe = 1'b0;
          w_nextTrply = 1'b0;
          w_nextAbort = 1'b1;
        end else begin
          w_nextToCnt = r_toCnt - 1'b1;
        end
`endif
      end
      QVEC_HOLD: begin
        if (r_cnt == '0) begin
          w_nextState = QVEC_CLEAR;
          w_nextTdal  = '0;
          w_nextDalOe = 1'b0;
          w_nextDone  = 1'b1;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      QVEC_ABORT: begin
        w_nextState = QVEC_CLEAR;
      end
      QVEC_CLEAR: begin
        // Wait for both grant and DIN to drop so a stale grant cannot restart.
        if (!assert_vector && !w_rdinS) begin
          w_nextState = QVEC_IDLE;
        end
      end
      default: begin
        w_nextState = QVEC_IDLE;
        w_nextTdal  = '0;
        w_nextDalOe = 1'b0;
        w_nextTrply = 1'b0;
      end
    endcase
    w_nextBusy = (w_nextState != QVEC_IDLE);
  end

  assign TDAL         = r_tdal;
  assign dal_oe       = r_dalOe;
  assign TRPLY        = r_trply;
  assign vector_done  = r_done;
  assign vector_abort = r_abort;
  assign busy         = r_busy;

endmodule

// File: tb/tb_qvec_reply.sv
// -----------------------------------------------------------------------------
// tb_qvec_reply
// Self-checking bench for qvec_reply. Each transfer is described by the vector,
// the cycle at which the master drops DIN, and whether the grant is left stale.
// Expected event times are worked out from the handshake rules: DIN takes two
// cycles through the synchronizer and one more for the sequencer to act.
// -----------------------------------------------------------------------------
module tb_qvec_reply;

  localparam int SETUP_CYC   = 2;
  localparam int HOLD_CYC    = 1;
  localparam int TIMEOUT_CYC = 10;

  logic        qclk = 1'b0;
  logic        reset;
  logic        assert_vector;
  logic        RDIN;
  logic [15:0] vector;
  logic [21:0] TDAL;
  logic        dal_oe;
  logic        TRPLY;
  logic        vector_done;
  logic        vector_abort;
  logic        busy;

  int checks     = 0;
  int passes     = 0;
  int violations = 0;

  qvec_reply #(
    .SETUP_CYC   (SETUP_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .qclk          (qclk),
    .reset         (reset),
    .assert_vector (assert_vector),
    .RDIN          (RDIN),
    .vector        (vector),
    .TDAL          (TDAL),
    .dal_oe        (dal_oe),
    .TRPLY         (TRPLY),
    .vector_done   (vector_done),
    .vector_abort  (vector_abort),
    .busy          (busy)
  );

  // 20 MHz bus clock.
  always #25 qclk = ~qclk;

  // Bus rules that must hold on every cycle: no reply without drivers, and
  // never both completion and abort at once.
  always @(negedge qclk) begin
    if (TRPLY && !dal_oe) violations++;
    if (vector_done && vector_abort) violations++;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic stepCycle();
    @(posedge qclk);
    #1;
  endtask

  // Runs one transfer. RDIN and the grant rise at step 0; RDIN drops right
  // after edge dropAt. Times are recorded as edge indices since the start.
  task automatic applyStimulus(input logic [15:0] vec, input int dropAt,
                               input bit staleGrant);
    int tDalOn = -1, tDalOff = -1, tRplyOn = -1, tRplyOff = -1;
    int tDone = -1, tAbort = -1, nDone = 0, nAbort = 0;
    int eRplyOn, eRplyOff, eDalOff, eDone, eAbort, eNDone, eNAbort;
    int f, maxStep, avDropAt, reOn;
    bit busyAtOn = 1'b0;
    bit aborted, timedOut;
    logic [21:0] tdalFirst = '0, tdalLast = '0, expTdal;

    vector        = vec;
    assert_vector = 1'b1;
    RDIN          = 1'b1;
    avDropAt      = staleGrant ? -1 : ((dropAt < 3) ? 3 : dropAt);
    maxStep       = dropAt + HOLD_CYC + 8;

    for (int s = 1; s <= maxStep; s++) begin
      stepCycle();
      if (dal_oe && tDalOn < 0) begin
        tDalOn    = s;
        tdalFirst = TDAL;
        busyAtOn  = busy;
        vector    = 16'($urandom);
      end
      if (dal_oe) tdalLast = TDAL;
      if (!dal_oe && tDalOn >= 0 && tDalOff < 0) tDalOff = s;
      if (TRPLY && tRplyOn < 0) tRplyOn = s;
      if (!TRPLY && tRplyOn >= 0 && tRplyOff < 0) tRplyOff = s;
      if (vector_done) begin nDone++; if (tDone < 0) tDone = s; end
      if (vector_abort) begin nAbort++; if (tAbort < 0) tAbort = s; end
      if (s == dropAt) RDIN = 1'b0;
      if (s == avDropAt) assert_vector = 1'b0;
    end

    // Reference timing: drivers on at edge 3, sequencer reacts to the DIN drop
    // at edge f. A drop seen no later than the setup expiry is an abort.
    f        = dropAt + 3;
    expTdal  = {6'b0, vec[15:2], 2'b00};
    aborted  = (dropAt <= SETUP_CYC);
    timedOut = 1'b0;
`ifdef QVEC_TIMEOUT_EN
    timedOut = !aborted && (f > 3 + SETUP_CYC + TIMEOUT_CYC);
`endif
    if (aborted) begin
      eRplyOn = -1; eRplyOff = -1; eDalOff = f;
      eDone = -1; eNDone = 0; eAbort = f; eNAbort = 1;
    end else if (timedOut) begin
      eRplyOn = 3 + SETUP_CYC; eRplyOff = 3 + SETUP_CYC + TIMEOUT_CYC;
      eDalOff = eRplyOff; eDone = -1; eNDone = 0; eAbort = eRplyOff; eNAbort = 1;
    end else begin
      eRplyOn = 3 + SETUP_CYC; eRplyOff = f; eDalOff = f + HOLD_CYC;
      eDone = eDalOff; eNDone = 1; eAbort = -1; eNAbort = 0;
    end

    checkOutput("dalOnTime",  tDalOn,    3);
    checkOutput("busyAtOn",   busyAtOn,  1);
    checkOutput("tdalFirst",  tdalFirst, expTdal);
    checkOutput("tdalLast",   tdalLast,  expTdal);
    checkOutput("rplyOnTime", tRplyOn,   eRplyOn);
    checkOutput("rplyOffTime", tRplyOff, eRplyOff);
    checkOutput("dalOffTime", tDalOff,   eDalOff);
    checkOutput("doneTime",   tDone,     eDone);
    checkOutput("doneCount",  nDone,     eNDone);
    checkOutput("abortTime",  tAbort,    eAbort);
    checkOutput("abortCount", nAbort,    eNAbort);
    checkOutput("tdalAfter",  TDAL,      0);

    if (staleGrant) begin
      reOn = 0;
      for (int s = 0; s < 6; s++) begin
        stepCycle();
        if (dal_oe) reOn++;
      end
      checkOutput("staleNoRestart", reOn, 0);
      checkOutput("staleBusy", busy, 1);
      assert_vector = 1'b0;
    end
    stepCycle();
    stepCycle();
    checkOutput("idleBusy", busy, 0);
  endtask

  initial begin
    int dropAt;
    logic [15:0] vec;
    int n;

    reset         = 1'b1;
    assert_vector = 1'b0;
    RDIN          = 1'b0;
    vector        = '0;
    repeat (3) @(posedge qclk);
    #1;
    checkOutput("rstTdal",  TDAL,         0);
    checkOutput("rstDalOe", dal_oe,       0);
    checkOutput("rstTrply", TRPLY,        0);
    checkOutput("rstDone",  vector_done,  0);
    checkOutput("rstAbort", vector_abort, 0);
    checkOutput("rstBusy",  busy,         0);
    reset = 1'b0;
    stepCycle();
    stepCycle();

    $display("[TB] directed transfers");
    applyStimulus(16'o000154, 11, 1'b0);
    applyStimulus(16'o000157, 8, 1'b1);
    applyStimulus(16'o000154, 1, 1'b0);
    applyStimulus(16'o177777, 2, 1'b0);
    applyStimulus(16'o000154, 6, 1'b0);
    applyStimulus(16'($urandom), 520, 1'b0);

    $display("[TB] random transfers");
    for (int i = 0; i < 12; i++) begin
      vec    = 16'($urandom);
      dropAt = int'($urandom_range(1, 12));
      applyStimulus(vec, dropAt, 1'($urandom_range(0, 1)));
    end

    $display("[TB] mid-transfer reset");
    vector        = 16'o000154;
    assert_vector = 1'b1;
    RDIN          = 1'b1;
    n = 0;
    while (!TRPLY && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("rplyBeforeReset", TRPLY, 1);
    #10 reset = 1'b1;
    #1;
    checkOutput("rstAsyncTrply", TRPLY,  0);
    checkOutput("rstAsyncDalOe", dal_oe, 0);
    checkOutput("rstAsyncTdal",  TDAL,   0);
    checkOutput("rstAsyncBusy",  busy,   0);
    assert_vector = 1'b0;
    RDIN          = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    stepCycle();

    applyStimulus(16'o000300, 9, 1'b0);

    checkOutput("protocolViolations", violations, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
